// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO addresses, status layout, FIFO default.
package dmem_pkg;

  localparam int unsigned ADDR_W            = 12;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned DBG_DEPTH_DEFAULT = 8;

  localparam logic [11:0] ADDR_DBG_TX     = 12'hFF0;
  localparam logic [11:0] ADDR_DBG_STATUS = 12'hFF1;
  localparam logic [11:0] ADDR_CYCLE      = 12'hFF2;
  localparam logic [11:0] ADDR_SCRATCH    = 12'hFF3;

  localparam int unsigned ST_FULL_BIT  = 4;
  localparam int unsigned ST_EMPTY_BIT = 5;
  localparam int unsigned ST_OVF_BIT   = 6;

  // Count field saturates at 15 so deeper FIFOs still fit the 4-bit field.
  function automatic logic [31:0] status_word(input logic [31:0] count, input logic full,
                                              input logic empty, input logic ovf);
    logic [31:0] w;
    w               = '0;
    w[3:0]          = (count > 32'd15) ? 4'hF : count[3:0];
    w[ST_FULL_BIT]  = full;
    w[ST_EMPTY_BIT] = empty;
    w[ST_OVF_BIT]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/debug_fifo.sv
// Debug FIFO: power-of-two depth, count-based full/empty, head shown only while non-empty.
module debug_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && reset) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: inline RAM plus debug TX FIFO, status, cycle counter and scratch MMIO.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 2048,
  parameter int unsigned DBG_DEPTH = DBG_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        debug_valid,
  output logic [31:0] debug_data,
  input  logic        debug_ready
);

  localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned CW     = $clog2(DBG_DEPTH) + 1;

  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       q_dmem_q, q_dmem_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       scratch_q, scratch_d;
  logic              ovf_q, ovf_d;

  logic              ram_hit_c, hit_tx_c, hit_st_c, hit_cyc_c, hit_scr_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic              push_req_c, pop_c, ovf_event_c;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       fifo_head;

  assign ram_hit_c = (32'(address_dmem) < RAM_WORDS);
  assign ram_idx_c = RAM_AW'(address_dmem);
  assign hit_tx_c  = (address_dmem == ADDR_DBG_TX);
  assign hit_st_c  = (address_dmem == ADDR_DBG_STATUS);
  assign hit_cyc_c = (address_dmem == ADDR_CYCLE);
  assign hit_scr_c = (address_dmem == ADDR_SCRATCH);

  assign pop_c       = ~fifo_empty & debug_ready;
  assign push_req_c  = wren & hit_tx_c;
  assign ovf_event_c = push_req_c & fifo_full & ~pop_c;

  debug_fifo #(.DEPTH(DBG_DEPTH)) u_debug_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req_c),
    .pop   (pop_c),
    .din   (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Read mux uses pre-edge state so every load sees values from before any same-cycle write.
  always_comb begin
    q_dmem_d = '0;
    if (ram_hit_c)      q_dmem_d = ram[ram_idx_c];
    else if (hit_st_c)  q_dmem_d = status_word(32'(fifo_count), fifo_full, fifo_empty, ovf_q);
    else if (hit_cyc_c) q_dmem_d = cycle_q;
    else if (hit_scr_c) q_dmem_d = scratch_q;

    cycle_d = cycle_q + 32'd1;
    if (wren && hit_cyc_c) cycle_d = data;

    scratch_d = scratch_q;
    if (wren && hit_scr_c) scratch_d = data;

    // A fresh overflow beats a same-cycle clear.
    ovf_d = ovf_event_c | (ovf_q & ~(wren & hit_st_c));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_dmem_q  <= '0;
      cycle_q   <= '0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      q_dmem_q  <= q_dmem_d;
      cycle_q   <= cycle_d;
      scratch_q <= scratch_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wren && ram_hit_c) ram[ram_idx_c] <= data;
  end

  assign q_dmem      = q_dmem_q;
  assign debug_valid = ~fifo_empty;
  assign debug_data  = fifo_head;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: load expectations queued at drive time, popped after the edge.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clock;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        debug_valid;
  logic [31:0] debug_data;
  logic        debug_ready;

  int checks;
  int failures;
  logic [31:0] exp_q [$];
  logic [31:0] mfifo [$];

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .debug_valid  (debug_valid),
    .debug_data   (debug_data),
    .debug_ready  (debug_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // One bus cycle: drive on the falling edge, return just after the rising edge.
  task automatic cyc(input logic [11:0] a, input logic [31:0] d, input logic we, input logic rdy);
    @(negedge clock);
    address_dmem = a;
    data         = d;
    wren         = we;
    debug_ready  = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    #23;
    checks++;
    if (q_dmem !== 32'h0 || debug_valid !== 1'b0 || debug_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state q=%h valid=%b data=%h want 0/0/0", q_dmem, debug_valid, debug_data);
    end
    @(negedge clock);
    reset        = 1'b1;
    address_dmem = ADDR_CYCLE;
    wren         = 1'b0;
    exp_q.push_back(32'h0);
    @(posedge clock);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp) begin
      failures++;
      $display("FAIL cycle_first_edge got=%h want=%h", q_dmem, exp);
    end
    exp_q.push_back(32'h1);
    cyc(ADDR_CYCLE, 32'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp) begin
      failures++;
      $display("FAIL cycle_second got=%h want=%h", q_dmem, exp);
    end
    exp_q.push_back(32'h20);
    cyc(ADDR_DBG_STATUS, 32'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp) begin
      failures++;
      $display("FAIL status_after_reset got=%h want=%h", q_dmem, exp);
    end
  endtask

  task automatic test_ram();
    logic [11:0] ta [6];
    logic [31:0] td [6];
    logic        tw [6];
    logic [31:0] te [6];
    logic [31:0] exp;
    ta = '{12'h010, 12'h010, 12'h010, 12'h010, 12'h7FF, 12'h7FF};
    td = '{32'hDEADBEEF, 32'h0, 32'h11111111, 32'h0, 32'hCAFEF00D, 32'h0};
    tw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    te = '{32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h11111111, 32'h0, 32'hCAFEF00D};
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || i == 4) begin
        cyc(ta[i], td[i], tw[i], 1'b0);
      end else begin
        exp_q.push_back(te[i]);
        cyc(ta[i], td[i], tw[i], 1'b0);
        exp = exp_q.pop_front();
        checks++;
        if (q_dmem !== exp) begin
          failures++;
          $display("FAIL ram_step%0d addr=%h got=%h want=%h", i, ta[i], q_dmem, exp);
        end
      end
    end
  endtask

  task automatic test_unmapped();
    logic [11:0] ra [4];
    logic [31:0] exp;
    ra = '{12'h900, 12'h800, ADDR_DBG_TX, 12'hFF4};
    cyc(12'h900, 32'h55, 1'b1, 1'b0);
    cyc(12'hFFF, 32'h77, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      cyc(ra[i], 32'h0, 1'b0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (q_dmem !== exp) begin
        failures++;
        $display("FAIL unmapped_rd addr=%h got=%h want=%h", ra[i], q_dmem, exp);
      end
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] exp;
    logic [31:0] st_exp [3];
    st_exp = '{32'h58, 32'h60, 32'h20};
    for (int i = 1; i <= 9; i++) begin
      cyc(ADDR_DBG_TX, 32'(i), 1'b1, 1'b0);
      if (i <= 8) mfifo.push_back(32'(i));
    end
    exp_q.push_back(st_exp[0]);
    cyc(ADDR_DBG_STATUS, 32'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp) begin
      failures++;
      $display("FAIL status_overflow got=%h want=%h", q_dmem, exp);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (debug_valid !== 1'b1 || debug_data !== mfifo[0]) begin
        failures++;
        $display("FAIL head_hold valid=%b data=%h want 1/%h", debug_valid, debug_data, mfifo[0]);
      end
      cyc(12'h900, 32'h0, 1'b0, 1'b0);
    end
    while (mfifo.size() > 0) begin
      exp = mfifo.pop_front();
      checks++;
      if (debug_valid !== 1'b1 || debug_data !== exp) begin
        failures++;
        $display("FAIL drain valid=%b data=%h want 1/%h", debug_valid, debug_data, exp);
      end
      cyc(12'h900, 32'h0, 1'b0, 1'b1);
    end
    checks++;
    if (debug_valid !== 1'b0 || debug_data !== 32'h0) begin
      failures++;
      $display("FAIL drained_empty valid=%b data=%h want 0/0", debug_valid, debug_data);
    end
    exp_q.push_back(st_exp[1]);
    cyc(ADDR_DBG_STATUS, 32'h0, 1'b0, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp) begin
      failures++;
      $display("FAIL status_sticky got=%h want=%h", q_dmem, exp);
    end
    cyc(ADDR_DBG_STATUS, 32'hFFFFFFFF, 1'b1, 1'b0);
    exp_q.push_back(st_exp[2]);
    cyc(ADDR_DBG_STATUS, 32'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp) begin
      failures++;
      $display("FAIL status_cleared got=%h want=%h", q_dmem, exp);
    end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      cyc(ADDR_DBG_TX, 32'h100 + 32'(i), 1'b1, 1'b0);
      mfifo.push_back(32'h100 + 32'(i));
    end
    checks++;
    if (debug_data !== mfifo[0]) begin
      failures++;
      $display("FAIL full_head got=%h want=%h", debug_data, mfifo[0]);
    end
    cyc(ADDR_DBG_TX, 32'hA5, 1'b1, 1'b1);
    void'(mfifo.pop_front());
    mfifo.push_back(32'hA5);
    exp_q.push_back(32'h18);
    cyc(ADDR_DBG_STATUS, 32'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp) begin
      failures++;
      $display("FAIL status_full_popush got=%h want=%h", q_dmem, exp);
    end
    while (mfifo.size() > 0) begin
      exp = mfifo.pop_front();
      checks++;
      if (debug_valid !== 1'b1 || debug_data !== exp) begin
        failures++;
        $display("FAIL popush_drain valid=%b data=%h want 1/%h", debug_valid, debug_data, exp);
      end
      cyc(12'h900, 32'h0, 1'b0, 1'b1);
    end
    exp_q.push_back(32'h20);
    cyc(ADDR_DBG_STATUS, 32'h0, 1'b0, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp) begin
      failures++;
      $display("FAIL status_popush_end got=%h want=%h", q_dmem, exp);
    end
  endtask

  task automatic test_cycle_wrap();
    logic [31:0] want [3];
    logic [31:0] exp;
    want = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
    cyc(ADDR_CYCLE, 32'hFFFFFFFE, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(want[i]);
      cyc(ADDR_CYCLE, 32'h0, 1'b0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (q_dmem !== exp) begin
        failures++;
        $display("FAIL cycle_wrap%0d got=%h want=%h", i, q_dmem, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) cyc(ADDR_DBG_TX, 32'h31 + 32'(i), 1'b1, 1'b0);
    cyc(ADDR_SCRATCH, 32'h1234, 1'b1, 1'b0);
    exp_q.push_back(32'h1234);
    cyc(ADDR_SCRATCH, 32'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp || debug_valid !== 1'b1 || debug_data !== 32'h31) begin
      failures++;
      $display("FAIL pre_reset q=%h valid=%b data=%h want %h/1/31", q_dmem, debug_valid, debug_data, exp);
    end
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (debug_valid !== 1'b0 || q_dmem !== 32'h0 || debug_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset valid=%b q=%h data=%h want 0/0/0", debug_valid, q_dmem, debug_data);
    end
    @(negedge clock);
    reset = 1'b1;
    exp_q.push_back(32'h0);
    cyc(ADDR_SCRATCH, 32'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp) begin
      failures++;
      $display("FAIL scratch_after_reset got=%h want=%h", q_dmem, exp);
    end
    exp_q.push_back(32'h20);
    cyc(ADDR_DBG_STATUS, 32'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (q_dmem !== exp || debug_valid !== 1'b0) begin
      failures++;
      $display("FAIL status_after_mid_reset got=%h valid=%b want=%h/0", q_dmem, debug_valid, exp);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    debug_ready  = 1'b0;
    test_reset();
    test_ram();
    test_unmapped();
    test_fifo_overflow();
    test_full_pop_push();
    test_cycle_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 2048, meaning RAM words mapped from address 0x000.
REQ-002 SHALL have parameter DBG_DEPTH, default 8, meaning debug FIFO entries (power of two).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port address_dmem  input  12  word address from processor.
REQ-006 SHALL have port data  input  32  store data from processor.
REQ-007 SHALL have port wren  input  1  store enable for address_dmem.
REQ-008 SHALL have port q_dmem  output  32  registered load data.
REQ-009 SHALL have port debug_valid  output  1  debug FIFO head valid (FIFO not empty).
REQ-010 SHALL have port debug_data  output  32  debug FIFO head word.
REQ-011 SHALL have port debug_ready  input  1  host accepts head; pop when debug_valid and debug_ready.

Function
REQ-012 SHALL decode: 0x000..RAM_WORDS-1 RAM; 0xFF0 DBG_TX; 0xFF1 DBG_STATUS; 0xFF2 CYCLE; 0xFF3 SCRATCH; all other addresses unmapped.
REQ-013 SHALL register q_dmem at each rising edge with read data of the address presented before that edge (1-cycle latency), on every cycle regardless of wren.
REQ-014 SHALL perform RAM writes at the rising edge when wren=1; a same-cycle read of that address returns old contents (read-before-write).
REQ-015 SHALL return 0 on reads of unmapped addresses and DBG_TX; writes there are ignored (except DBG_TX push).
REQ-016 SHALL push data into the debug FIFO on wren=1 to DBG_TX when not full, or when full and a pop occurs in the same cycle.
REQ-017 SHALL drop a DBG_TX write when full with no same-cycle pop, and set sticky overflow.
REQ-018 SHALL read DBG_STATUS as bits[3:0]=count (saturating at 15), bit4=full, bit5=empty, bit6=overflow, other bits 0, sampled pre-edge.
REQ-019 SHALL clear overflow on any write to DBG_STATUS; a same-cycle overflow event wins (overflow stays 1).
REQ-020 SHALL keep FIFO order strictly first-in first-out; a push into an empty FIFO appears on debug_data the next cycle (no bypass).
REQ-021 SHALL pop when debug_valid=1 and debug_ready=1; debug_ready while empty has no effect.
REQ-022 SHALL hold debug_data stable while debug_valid=1 and debug_ready=0.
REQ-023 SHALL increment a 32-bit CYCLE counter every cycle, wrapping 0xFFFFFFFF->0; read returns pre-edge value.
REQ-024 SHALL load CYCLE with data on a write (loaded value replaces that cycle's increment).
REQ-025 SHALL read/write SCRATCH as a plain 32-bit register.
REQ-026 SHALL wrap FIFO read/write pointers modulo DBG_DEPTH, with count distinguishing full from empty.

Reset
REQ-027 SHALL on reset low asynchronously set q_dmem=0, FIFO empty (debug_valid=0, debug_data=0), overflow=0, CYCLE=0, SCRATCH=0.
REQ-028 SHALL leave RAM contents unchanged by reset (undefined at power-up).
REQ-029 SHALL discard all FIFO contents on reset asserted mid-operation; no pop or push completes in that cycle.
REQ-030 SHALL resume normal operation on the first rising edge after reset deasserts; CYCLE reads 0 on that edge.

Structure
REQ-031 SHALL place address constants (0xFF0-0xFF3), status bit positions and default DBG_DEPTH in shared package dmem_pkg.
REQ-032 SHALL implement the debug FIFO as sub-module debug_fifo (push, pop, full, empty, count, head); RAM inferred inline.

Verification
REQ-033 SHALL cover: write 0xDEADBEEF to 0x010, then read 0x010 -> q_dmem=0xDEADBEEF one cycle after read address applied.
REQ-034 SHALL cover: 9 DBG_TX writes 1..9 with debug_ready=0 -> STATUS reads 0x58 (count 8, full, overflow); drain yields 1..8 in order, then debug_valid=0.
REQ-035 SHALL cover: FIFO full, DBG_TX write 0xA5 with debug_ready=1 same cycle -> pop of head, 0xA5 accepted, overflow stays 0.
REQ-036 SHALL cover: write CYCLE=0xFFFFFFFE, read CYCLE next cycles -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-037 SHALL cover: 3 entries queued, SCRATCH=0x1234, reset pulsed low mid-cycle -> immediately debug_valid=0, q_dmem=0; SCRATCH reads 0.
REQ-038 SHALL cover: write 0x55 to 0x900, read 0x900 -> q_dmem=0; overflow set then STATUS write -> bit6 reads 0.
